// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the 64x8 RAM march BIST.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWAsc,
        StRAsc,
        StWDesc,
        StRDesc,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned DEF_AW      = 6;
    localparam int unsigned DEF_DW      = 8;
    localparam int unsigned DEPTH       = 2 ** DEF_AW;
    localparam logic [7:0]  DEF_PATTERN = 8'h55;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// AW-bit up/down address counter; direction is latched on load so `last` never
// depends on the FSM's next-state logic.
module ram_bist_addr_gen #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dir,
    input  logic          step,
    output logic [AW-1:0] count,
    output logic          last
);

    localparam logic [AW-1:0] TOP = {AW{1'b1}};

    logic dir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            dir_q <= 1'b0;
        end else if (load) begin
            count <= dir ? TOP : '0;
            dir_q <= dir;
        end else if (step) begin
            count <= dir_q ? count - AW'(1) : count + AW'(1);
        end
    end

    // Terminal address by explicit compare, not by wrap-around.
    assign last = dir_q ? (count == '0) : (count == TOP);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST controller: owns the RAM control bus while busy, compares each read
// one cycle later, and reports the first failing address and data.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned    AW      = DEF_AW,
    parameter int unsigned    DW      = DEF_DW,
    parameter logic [DW-1:0]  PATTERN = DW'(DEF_PATTERN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [DW-1:0] mem_data,
    output logic          mem_r,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    input  logic [DW-1:0] mem_out
);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr;
    logic            addr_last, addr_load, addr_dir;
    logic            is_write, is_read, in_run, start_ok, mismatch;
    logic            cmp_vld_q;
    logic [AW-1:0]   cmp_addr_q;
    logic [DW-1:0]   cmp_exp_q;

    assign is_write = (state_q == StWAsc) || (state_q == StWDesc);
    assign is_read  = (state_q == StRAsc) || (state_q == StRDesc);
    assign in_run   = (state_q != StIdle) && (state_q != StDone);
    assign start_ok = start && !in_run;
    assign mismatch = in_run && cmp_vld_q && (mem_out != cmp_exp_q);

    ram_bist_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (addr_load),
        .dir   (addr_dir),
        .step  (is_write || is_read),
        .count (addr),
        .last  (addr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StWAsc;
            StWAsc:         if (addr_last) state_d = StRAsc;
            StRAsc:         if (addr_last) state_d = StWDesc;
            StWDesc:        if (addr_last) state_d = StRDesc;
            StRDesc:        if (addr_last) state_d = StCheck;
            StCheck:        state_d = StDone;
            default:        state_d = StIdle;
        endcase
        // A late compare may hit in the next phase's first cycle or in CHECK.
        if (mismatch) state_d = StDone;
    end

    always_comb begin
        busy      = in_run;
        done      = (state_q == StDone);
        mem_en    = is_write || is_read;
        mem_r     = is_read;
        mem_addr  = mem_en ? addr : '0;
        mem_data  = '0;
        if (state_q == StWAsc)  mem_data = PATTERN;
        if (state_q == StWDesc) mem_data = ~PATTERN;
        addr_load = (state_d != state_q) &&
                    (state_d inside {StWAsc, StRAsc, StWDesc, StRDesc});
        addr_dir  = (state_d == StWDesc) || (state_d == StRDesc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            cmp_exp_q  <= '0;
        end else begin
            cmp_vld_q  <= is_read && !mismatch;
            cmp_addr_q <= addr;
            cmp_exp_q  <= (state_q == StRAsc) ? PATTERN : ~PATTERN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch) begin
            pass      <= 1'b0;
            fail_addr <= cmp_addr_q;
            fail_data <= mem_out;
        end else if (state_q == StCheck) begin
            pass      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with a stuck-at-0 fault, and a march
// model predicting every cycle's bus activity and the final verdict.
module tb_ram_bist_ctrl;
    import ram_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, pass;
    logic [5:0] fail_addr, mem_addr;
    logic [7:0] fail_data, mem_data, mem_out;
    logic       mem_r, mem_en;

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .mem_data  (mem_data),
        .mem_r     (mem_r),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_out   (mem_out)
    );

    always #5 clk = ~clk;

    // RAM with optional stuck-at-0 bits at one address
    logic [7:0] ram [DEPTH];
    int         f_addr = -1;
    logic [7:0] f_mask = 8'h00;

    always @(posedge clk) begin
        if (mem_en && mem_r) begin
            mem_out <= (int'(mem_addr) == f_addr) ? (ram[mem_addr] & ~f_mask) : ram[mem_addr];
        end else begin
            mem_out <= 8'hzz;
            if (mem_en) begin
                ram[mem_addr] <= (int'(mem_addr) == f_addr) ? (mem_data & ~f_mask) : mem_data;
            end
        end
    end

    // Model: march sequence as a list of accesses indexed by cycle number
    int         acc_addr [1:256];
    bit         acc_r    [1:256];
    logic [7:0] acc_data [1:256];
    int         done_cyc, last_acc;
    bit         m_failed;
    int         m_faddr;
    logic [7:0] m_fdata;

    int  n_chk = 0, n_fail = 0;
    int  cyc = 0, obs_done = 0;
    bit  trk = 1'b0;
    bit  in_run, acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic build_model(input int fa, input logic [7:0] fm);
        logic [7:0] mm [DEPTH];
        logic [7:0] v;
        int         k, a;
        m_failed = 0; m_faddr = 0; m_fdata = 0;
        foreach (mm[i]) mm[i] = 8'h00;
        done_cyc = 258; last_acc = 256;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 64; i++) begin
                k = p * 64 + i + 1;
                a = (p < 2) ? i : 63 - i;
                acc_addr[k] = a;
                acc_r[k]    = p[0];
                acc_data[k] = (p < 2) ? DEF_PATTERN : ~DEF_PATTERN;
                if (!acc_r[k]) begin
                    mm[a] = acc_data[k];
                end else begin
                    v = (a == fa) ? (mm[a] & ~fm) : mm[a];
                    if (v != acc_data[k] && !m_failed) begin
                        m_failed = 1; m_faddr = a; m_fdata = v;
                        done_cyc = k + 2; last_acc = k + 1;
                    end
                end
            end
        end
    endtask

    // Compare process: cycle k is the interval after edge k-1 (start sampled at edge 0)
    always @(posedge clk) begin
        #1;
        if (trk) begin
            cyc    = cyc + 1;
            in_run = (cyc < done_cyc);
            acc    = (cyc <= last_acc);
            chk("busy", {31'b0, busy}, {31'b0, in_run});
            chk("done", {31'b0, done}, {31'b0, !in_run});
            chk("mem_en", {31'b0, mem_en}, {31'b0, acc});
            chk("mem_r", {31'b0, mem_r}, {31'b0, acc && acc_r[cyc]});
            chk("mem_addr", {26'b0, mem_addr}, acc ? acc_addr[cyc] : 0);
            if (!acc || !acc_r[cyc]) chk("mem_data", {24'b0, mem_data}, acc ? {24'b0, acc_data[cyc]} : 0);
            chk("pass", {31'b0, pass}, {31'b0, !in_run && !m_failed});
            chk("fail_addr", {26'b0, fail_addr}, (!in_run && m_failed) ? m_faddr : 0);
            chk("fail_data", {24'b0, fail_data}, (!in_run && m_failed) ? {24'b0, m_fdata} : 0);
            if (done && obs_done == 0) obs_done = cyc;
            if (cyc >= done_cyc + 2) trk = 1'b0;
        end
    end

    task automatic launch(input int fa, input logic [7:0] fm);
        f_addr = fa; f_mask = fm;
        build_model(fa, fm);
        @(negedge clk);
        start = 1'b1; cyc = 0; obs_done = 0; trk = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 400 && trk; i++) @(negedge clk);
        if (trk) begin
            n_chk++; n_fail++;
            $display("FAIL run_timeout: still running at cycle %0d, expected done by %0d", cyc, done_cyc);
            trk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 400 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, {31'b0, busy}, 0);
        chk({name, "_done"}, {31'b0, done}, 0);
        chk({name, "_pass"}, {31'b0, pass}, 0);
        chk({name, "_mem_en"}, {31'b0, mem_en}, 0);
        chk({name, "_mem_addr"}, {26'b0, mem_addr}, 0);
        chk({name, "_mem_data"}, {24'b0, mem_data}, 0);
        chk({name, "_fail_addr"}, {26'b0, fail_addr}, 0);
        chk({name, "_fail_data"}, {24'b0, fail_data}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle("idle_hold");
        end

        // Fault-free march
        launch(-1, 8'h00);
        wait_run();
        chk("clean_done_cycle", obs_done, 258);
        chk("clean_pass", {31'b0, pass}, 1);

        // Address 0, bit 0 stuck-at-0
        launch(0, 8'h01);
        wait_run();
        chk("a0_done_cycle", obs_done, 67);
        chk("a0_fail_data", {24'b0, fail_data}, 32'h54);
        chk("a0_fail_addr", {26'b0, fail_addr}, 32'h00);

        // Restart from a failed DONE with a good RAM
        launch(-1, 8'h00);
        wait_run();
        chk("rerun_done_cycle", obs_done, 258);
        chk("rerun_pass", {31'b0, pass}, 1);

        // Address 0x3F, bit 7 stuck-at-0
        launch(63, 8'h80);
        wait_run();
        chk("a3f_done_cycle", obs_done, 195);
        chk("a3f_fail_data", {24'b0, fail_data}, 32'h2A);
        chk("a3f_fail_addr", {26'b0, fail_addr}, 32'h3F);

        // Start while busy is ignored; reset mid-run aborts with no result
        launch(-1, 8'h00);
        wait_cyc(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(150);
        trk = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort");
        repeat (3) @(negedge clk);
        chk_idle("abort_hold");
        launch(-1, 8'h00);
        wait_run();
        chk("after_abort_done_cycle", obs_done, 258);
        chk("after_abort_pass", {31'b0, pass}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Built-in self-test initiator for the 64x8 synchronous RAM: drives the RAM's data/r/address/en inputs and checks its registered out bus. On `start` it runs a four-phase march (write ascending, read-verify ascending, write-inverse descending, read-verify descending). It then reports pass/fail with the first failing address and read value. It sits beside the RAM and owns its control bus while `busy`.

## Interface
- `AW`, 6, RAM address width; depth = 2**AW.
- `DW`, 8, RAM data width.
- `PATTERN`, 8'h55, background word P; inverse phases use ~P.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request, honoured only in IDLE or DONE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  high in DONE; held until the next accepted `start` or `rst`.
- `pass`  out  1  valid when `done`; 1 = no mismatch.
- `fail_addr`  out  AW  address of the first mismatch; 0 if pass.
- `fail_data`  out  DW  value read at `fail_addr`; 0 if pass.
- `mem_data`  out  DW  to RAM `data`.
- `mem_r`  out  1  to RAM `r`; 1 = read, 0 = write.
- `mem_addr`  out  AW  to RAM `address`.
- `mem_en`  out  1  to RAM `en`.
- `mem_out`  in  DW  from RAM `out`, registered, one-cycle read latency.

## Operation
- States:
  - IDLE → W_ASC (write P, addr 0→63).
  - W_ASC → R_ASC (read, expect P, 0→63).
  - R_ASC → W_DESC (write ~P, 63→0).
  - W_DESC → R_DESC (read, expect ~P, 63→0).
  - R_DESC → CHECK → DONE.
- One RAM access per cycle in every phase. The phase advances after the terminal address (63 ascending, 0 descending). The address counter reloads 0 or 63 on phase entry.
- Read compare pipeline:
  - A read issued in cycle t registers `cmp_vld`, `cmp_addr` and `cmp_exp`.
  - In cycle t+1, `mem_out` is compared against `cmp_exp`.
  - The compare overlaps the next phase's first cycle. CHECK exists only to compare the final R_DESC read.
- Mismatch:
  - Capture `cmp_addr` → `fail_addr` and `mem_out` → `fail_data`, clear `pass`, and go to DONE at the same edge.
  - The access already driven in the detecting cycle completes; no further accesses follow.
- Only the first mismatch is recorded.
- `mem_en`=0, `mem_r`=0, `mem_addr`=0 and `mem_data`=0 in IDLE, CHECK and DONE. `mem_out` is ignored there, including the RAM's Z value.
- All `mem_*` outputs decode from state and counter registers only. There is no combinational path from `mem_out` or `start`.
- An accepted `start` from DONE clears `done`, `pass`, `fail_addr` and `fail_data`.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (`pass`=0).
- `rst` mid-run returns to IDLE at the next edge. `mem_en` is 0 in the following cycle; no partial result is reported.
- `start` sampled at edge 0; cycle numbering follows from there:
  - cycles 1–64: W_ASC
  - cycles 65–128: R_ASC
  - cycles 129–192: W_DESC
  - cycles 193–256: R_DESC
  - cycle 257: CHECK
  - cycle 258: `done`=1, `busy`=0
- Mismatch on a read issued in cycle t: `done`=1 in cycle t+2.
- Address arithmetic is AW-bit. Phase termination is decided by comparison against 63 or 0, never by wrap-around.

## Structure
- Package `ram_bist_pkg` holds:
  - the state encoding (IDLE, W_ASC, R_ASC, W_DESC, R_DESC, CHECK, DONE)
  - `DEPTH`
  - the default `PATTERN`
- Sub-module `ram_bist_addr_gen` is an AW-bit up/down counter with `load`, `dir` and a `last` flag.
- The FSM and compare pipeline live in `ram_bist_ctrl`.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs 0, `mem_en`=0; `start` held low keeps IDLE indefinitely.
- Fault-free RAM, pulse `start` → writes of 0x55 at addresses 0..63, reads 0..63, writes 0xAA at 63..0, reads 63..0. Then `done`=1 in cycle 258, `pass`=1, `fail_addr`=0.
- RAM bit0 of address 0 stuck-at-0 → read returns 0x54 in R_ASC. `done` in cycle 67, `pass`=0, `fail_addr`=0x00, `fail_data`=0x54.
- RAM bit7 of address 0x3F stuck-at-0 → R_ASC passes; the R_DESC first read returns 0x2A. `done` in cycle 195, `fail_addr`=0x3F, `fail_data`=0x2A.
- Pulse `start` at cycle 100 and assert `rst` at cycle 150 → the second start is ignored. After reset: IDLE, `mem_en`=0 next cycle; a new `start` completes the full 258-cycle pass.
- From DONE with `pass`=0, pulse `start` with a fault-free RAM → flags clear in cycle 1 and `pass`=1 at cycle 258.
